// File: rtl/intl_rst_seq_if.sv
// Signal bundle between the INTL block / PS register bank and the
// interlock reset sequencer. Clock and reset stay plain ports on the modules.
//   slave  : the sequencer itself
//   master : the environment that drives the interlock state and reset requests
interface intl_rst_seq_if;
  logic [15:0] i_intl_state;
  logic [15:0] i_intl_mask;
  logic        i_rst_req;
  logic        i_sys_rst_flag;
  logic        o_intl_OC_rst;
  logic        o_intl_POC_rst;
  logic        o_intl_clr;
  logic [15:0] o_first_fault;
  logic        o_fault_latched;
  logic        o_busy;
  logic        o_rst_fail;
  logic [2:0]  o_seq_state;
  logic [31:0] o_fault_ts;

  modport slave (
    input  i_intl_state, i_intl_mask, i_rst_req, i_sys_rst_flag,
    output o_intl_OC_rst, o_intl_POC_rst, o_intl_clr, o_first_fault,
           o_fault_latched, o_busy, o_rst_fail, o_seq_state, o_fault_ts
  );

  modport master (
    output i_intl_state, i_intl_mask, i_rst_req, i_sys_rst_flag,
    input  o_intl_OC_rst, o_intl_POC_rst, o_intl_clr, o_first_fault,
           o_fault_latched, o_busy, o_rst_fail, o_seq_state, o_fault_ts
  );
endinterface

// File: rtl/intl_rst_seq.sv
// Interlock first-fault capture and hardware reset sequencer (AXI clock domain).
// Captures the masked interlock word at the first fault, and on a PS request
// (rising i_rst_req) or a DTR reset (falling i_sys_rst_flag) runs:
// pulse OC/POC reset lines -> settle -> clear INTL latches -> verify clean.
// Optional build macro INTL_RST_SEQ_TIMESTAMP_EN adds a free-running 32-bit
// cycle counter whose value is stored in o_fault_ts at capture; without it
// o_fault_ts is tied to zero.
module intl_rst_seq #(
  parameter int HW_RST_PULSE = 100,
  parameter int SETTLE_CYC   = 1000,
  parameter int CHECK_CYC    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  intl_rst_seq_if.slave bus
);

  localparam int MAXP_A = (HW_RST_PULSE > SETTLE_CYC) ? HW_RST_PULSE : SETTLE_CYC;
  localparam int MAXP   = (MAXP_A > CHECK_CYC) ? MAXP_A : CHECK_CYC;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] PULSE_LAST  = CW'(HW_RST_PULSE - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE  = 3'd1,
    SETTLE = 3'd2,
    CLEAR  = 3'd3,
    CHECK  = 3'd4,
    FAIL   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    dtr_sync_q;
  logic          dtr_prev_q;
  logic          req_q;

  logic          oc_rst_q;
  logic          poc_rst_q;
  logic          clr_q;
  logic [15:0]   first_fault_q;
  logic          latched_q;
  logic          busy_q;
  logic          rst_fail_q;

  logic [15:0]   masked;
  logic          start;
  logic          capture;
  logic          chk_pass;
  logic          chk_fail;

  assign masked = bus.i_intl_state & ~bus.i_intl_mask;

  // Start pulse: rising PS request, or falling edge of the synchronized DTR reset.
  assign start = (bus.i_rst_req & ~req_q) | (dtr_prev_q & ~dtr_sync_q[1]);

  // Capture is blocked while the reset lines are being exercised, since the
  // INTL inputs glitch during that window.
  assign capture = ~latched_q & ((state_q == IDLE) | (state_q == FAIL)) & (|masked);

  // DTR 2-FF synchronizer plus edge-detect history; PS request edge register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dtr_sync_q <= 2'b11;
      dtr_prev_q <= 1'b1;
      req_q      <= 1'b0;
    end else begin
      dtr_sync_q <= {dtr_sync_q[0], bus.i_sys_rst_flag};
      dtr_prev_q <= dtr_sync_q[1];
      req_q      <= bus.i_rst_req;
    end
  end

  // Sequencer state and shared phase counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter restarts from zero on every state change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    chk_pass = 1'b0;
    chk_fail = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = PULSE;
      end
      PULSE:  if (cnt_q == PULSE_LAST)  state_d = SETTLE;
      SETTLE: if (cnt_q == SETTLE_LAST) state_d = CLEAR;
      CLEAR:  state_d = CHECK;
      CHECK: begin
        if (cnt_q == CHECK_LAST) begin
          if (masked == 16'h0000) begin
            state_d  = IDLE;
            chk_pass = 1'b1;
          end else begin
            state_d  = FAIL;
            chk_fail = 1'b1;
          end
        end
      end
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Registered outputs; line levels follow the state being entered so they
  // line up exactly with o_seq_state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      oc_rst_q      <= 1'b1;
      poc_rst_q     <= 1'b0;
      clr_q         <= 1'b0;
      first_fault_q <= '0;
      latched_q     <= 1'b0;
      busy_q        <= 1'b0;
      rst_fail_q    <= 1'b0;
    end else begin
      oc_rst_q  <= (state_d != PULSE);
      poc_rst_q <= (state_d == PULSE);
      clr_q     <= (state_d == CLEAR);

      if ((state_q == IDLE) && start) begin
        busy_q     <= 1'b1;
        rst_fail_q <= 1'b0;
      end else if (chk_pass) begin
        busy_q     <= 1'b0;
      end else if (chk_fail) begin
        busy_q     <= 1'b0;
        rst_fail_q <= 1'b1;
      end

      if (capture) begin
        first_fault_q <= masked;
        latched_q     <= 1'b1;
      end else if (chk_pass) begin
        first_fault_q <= '0;
        latched_q     <= 1'b0;
      end
    end
  end

`ifdef INTL_RST_SEQ_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] fault_ts_q;

  // Free-running cycle counter and the timestamp taken at capture.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ts_cnt_q   <= '0;
      fault_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (capture)       fault_ts_q <= ts_cnt_q;
      else if (chk_pass) fault_ts_q <= '0;
    end
  end

  assign bus.o_fault_ts = fault_ts_q;
`else
  assign bus.o_fault_ts = '0;
`endif

  assign bus.o_intl_OC_rst   = oc_rst_q;
  assign bus.o_intl_POC_rst  = poc_rst_q;
  assign bus.o_intl_clr      = clr_q;
  assign bus.o_first_fault   = first_fault_q;
  assign bus.o_fault_latched = latched_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_rst_fail      = rst_fail_q;
  assign bus.o_seq_state     = state_q;

endmodule

// File: tb/tb_intl_rst_seq.sv
// Bench for intl_rst_seq: directed scenarios plus a randomized stretch,
// checked every cycle against a timeline model of the reset sequence.
module tb_intl_rst_seq;
  localparam int P = 4;
  localparam int S = 8;
  localparam int C = 2;
  localparam int L = P + S + 1 + C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  intl_rst_seq_if ifc();

  intl_rst_seq #(.HW_RST_PULSE(P), .SETTLE_CYC(S), .CHECK_CYC(C)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (ifc.slave)
  );

  // Environment: INTL latched faults (cleared by o_intl_clr) plus faults held
  // permanently by the bench.
  logic [15:0] live = '0;
  logic [15:0] hold = '0;
  logic [15:0] mask = '0;
  logic        req  = 1'b0;
  logic        flag = 1'b1;

  assign ifc.i_intl_state   = live | hold;
  assign ifc.i_intl_mask    = mask;
  assign ifc.i_rst_req      = req;
  assign ifc.i_sys_rst_flag = flag;

  int n_asrt = 0;
  int n_fail = 0;
  int n_clr  = 0;
  int n_oc   = 0;

  // Reference model: sequence phase derived from the edge count since start.
  int          cyc;
  bit          has_seq;
  int          n0;
  bit          mfail;
  logic [15:0] e_ff;
  bit          e_lat;
  bit          e_rf;
  int          e_ts;
  bit          req_prev;
  bit [2:0]    fh;

  always @(posedge clk or negedge rst_n) begin : model
    int          k;
    bit          idle;
    bit          cap_en;
    bit          st;
    logic [15:0] m;
    if (!rst_n) begin
      cyc      <= 0;
      has_seq  <= 1'b0;
      n0       <= 0;
      mfail    <= 1'b0;
      e_ff     <= '0;
      e_lat    <= 1'b0;
      e_rf     <= 1'b0;
      e_ts     <= 0;
      req_prev <= 1'b0;
      fh       <= 3'b111;
    end else begin
      m      = ifc.i_intl_state & ~ifc.i_intl_mask;
      k      = cyc - n0;
      idle   = !has_seq || (k > L) || (k == L && !mfail);
      cap_en = !e_lat && (idle || (has_seq && k == L && mfail));
      st     = (req && !req_prev) || (!fh[1] && fh[2]);
      if (cap_en && m != 16'h0000) begin
        e_ff  <= m;
        e_lat <= 1'b1;
        e_ts  <= cyc;
      end
      if (has_seq && k == L - 1) begin
        if (m == 16'h0000) begin
          e_ff  <= '0;
          e_lat <= 1'b0;
          e_ts  <= 0;
        end else begin
          mfail <= 1'b1;
          e_rf  <= 1'b1;
        end
      end
      if (idle && st) begin
        has_seq <= 1'b1;
        n0      <= cyc + 1;
        mfail   <= 1'b0;
        e_rf    <= 1'b0;
      end
      req_prev <= req;
      fh       <= {fh[1:0], flag};
      cyc      <= cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int k;
    int code;
    k    = cyc - n0;
    code = 0;
    if (has_seq) begin
      if (k < P)                code = 1;
      else if (k < P + S)       code = 2;
      else if (k == P + S)      code = 3;
      else if (k < L)           code = 4;
      else if (k == L && mfail) code = 5;
    end
    chk("seq_state",     32'(ifc.o_seq_state),     32'(code));
    chk("oc_rst",        32'(ifc.o_intl_OC_rst),   32'(code != 1));
    chk("poc_rst",       32'(ifc.o_intl_POC_rst),  32'(code == 1));
    chk("intl_clr",      32'(ifc.o_intl_clr),      32'(code == 3));
    chk("busy",          32'(ifc.o_busy),          32'(has_seq && k < L));
    chk("rst_fail",      32'(ifc.o_rst_fail),      32'(e_rf));
    chk("first_fault",   32'(ifc.o_first_fault),   32'(e_ff));
    chk("fault_latched", 32'(ifc.o_fault_latched), 32'(e_lat));
`ifdef INTL_RST_SEQ_TIMESTAMP_EN
    chk("fault_ts",      ifc.o_fault_ts,           32'(e_ts));
`else
    chk("fault_ts",      ifc.o_fault_ts,           32'd0);
`endif
  endtask

  // One clock: check at the falling edge, then let INTL react to a clear pulse.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      if (ifc.o_intl_clr === 1'b1) begin
        n_clr++;
        live = '0;
      end
      if (ifc.o_intl_OC_rst === 1'b0) n_oc++;
    end
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick(1);
    req = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    tick(3);

    // First fault wins: bit3, then bit5 one cycle later
    live = live | 16'h0008;
    tick(1);
    live = live | 16'h0020;
    tick(3);
    chk("t1_snapshot", 32'(ifc.o_first_fault), 32'h0008);
    chk("t1_latched",  32'(ifc.o_fault_latched), 32'd1);
    pulse_req();
    tick(L + 2);
    chk("t1_cleared", 32'(ifc.o_fault_latched), 32'd0);

    // Two bits in one cycle, one of them masked
    mask = 16'h0002;
    live = 16'h0006;
    tick(2);
    chk("t2_snapshot", 32'(ifc.o_first_fault), 32'h0004);
    pulse_req();
    tick(L + 2);
    mask = 16'h0000;

    // Clean sequence: OC low exactly P cycles, one clear pulse
    live = 16'h0010;
    tick(2);
    chk("t3_snapshot", 32'(ifc.o_first_fault), 32'h0010);
    n_clr = 0;
    n_oc  = 0;
    pulse_req();
    tick(L + 2);
    chk("t3_oc_cycles",  32'(n_oc),  32'(P));
    chk("t3_clr_pulses", 32'(n_clr), 32'd1);
    chk("t3_busy",       32'(ifc.o_busy), 32'd0);
    chk("t3_ff",         32'(ifc.o_first_fault), 32'd0);
    chk("t3_rst_fail",   32'(ifc.o_rst_fail), 32'd0);

    // Persistent fault: sequence fails, snapshot retained
    hold = 16'h0001;
    tick(2);
    pulse_req();
    tick(L + 2);
    chk("t4_rst_fail", 32'(ifc.o_rst_fail), 32'd1);
    chk("t4_ff",       32'(ifc.o_first_fault), 32'h0001);
    pulse_req();
    tick(1);
    chk("t4_fail_cleared_at_start", 32'(ifc.o_rst_fail), 32'd0);
    hold = 16'h0000;
    tick(L + 2);
    chk("t4_recovered", 32'(ifc.o_fault_latched), 32'd0);

    // DTR start; a PS request during SETTLE is dropped
    n_clr = 0;
    flag  = 1'b0;
    tick(3);
    chk("t5_dtr_started", 32'(ifc.o_busy), 32'd1);
    flag = 1'b1;
    tick(P + 2);
    pulse_req();
    tick(L + 6);
    chk("t5_single_clear", 32'(n_clr), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0)   live = live | 16'(32'd1 << $urandom_range(15));
      if ($urandom_range(40) == 0)  mask = 16'($urandom) & 16'($urandom);
      if ($urandom_range(90) == 0)  hold = ($urandom_range(1) == 0) ? 16'h0000 : 16'(32'd1 << $urandom_range(15));
      if ($urandom_range(11) == 0)  req  = ~req;
      if ($urandom_range(29) == 0)  flag = ~flag;
      tick(1);
    end
    req  = 1'b0;
    flag = 1'b1;
    hold = '0;
    mask = '0;
    tick(L + 6);

    // Asynchronous reset in the middle of PULSE
    pulse_req();
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_oc_async",   32'(ifc.o_intl_OC_rst),  32'd1);
    chk("t6_poc_async",  32'(ifc.o_intl_POC_rst), 32'd0);
    chk("t6_busy_async", 32'(ifc.o_busy),         32'd0);
    check_all();
    live = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);

    // Capture after reset (timestamp relative to reset release)
    live = 16'h0040;
    tick(3);
    chk("t7_snapshot", 32'(ifc.o_first_fault), 32'h0040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
